// File: rtl/de2i150_input_conditioner_pkg.sv
// Shared defaults for the DE2i-150 input conditioning path (slide switches / push keys).
package de2i150_input_pkg;

    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam int unsigned DEBOUNCE_MS      = 1;
    localparam int unsigned DEFAULT_TICK_DIV = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // The four push keys are active-low on the board.
    localparam logic [15:0] KEY_INVERT_MASK  = 16'h000F;

    typedef logic [15:0] in_word_t;

    function automatic int unsigned cnt_width(input int unsigned stable_ticks);
        return $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/de2i150_input_conditioner_debounce_bit.sv
// One conditioned bit: synchroniser, optional inversion, tick-qualified debounce,
// clean level flop and registered rise/fall pulses.
module de2i150_debounce_bit
    import de2i150_input_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STABLE_TICKS = 10,
    parameter logic        INVERT       = 1'b0,
    parameter logic        RESET_VALUE  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    input  logic tick,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned      CNT_W    = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
        s       = sync_q[SYNC_STAGES-1] ^ INVERT;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == clean_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = s;
                cnt_d   = '0;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: synchroniser resets to the idle level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_VALUE ^ INVERT}};
            cnt_q   <= '0;
            clean_q <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples its pre-edge inputs.
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/de2i150_input_conditioner.sv
// Conditions raw switch/key inputs for the PIO in_port: shared debounce prescaler plus per-bit cells.
// Optional sticky edge capture with irq when DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN is defined.
module de2i150_input_conditioner
    import de2i150_input_pkg::*;
#(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      SYNC_STAGES  = 2,
    parameter int unsigned      TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int unsigned      STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] INVERT_MASK  = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
    input  logic [WIDTH-1:0] capture_clr,
    output logic             irq,
`endif
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    localparam int unsigned      PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick;

    always_comb begin
        tick    = (presc_q == PRE_LAST);
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) presc_q <= '0;
        else          presc_q <= presc_d;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        de2i150_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS),
            .INVERT      (INVERT_MASK[i]),
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw_in    (raw_in[i]),
            .tick      (tick),
            .clean_out (clean_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end

    assign any_change = |(rise_pulse | fall_pulse);

`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q;

    // A new edge in the same cycle as its clear keeps the bit set.
    always_comb begin
        cap_d = (cap_q & ~capture_clr) | rise_pulse | fall_pulse;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
            irq_q <= 1'b0;
        end else begin
            cap_q <= cap_d;
            irq_q <= |cap_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_de2i150_input_conditioner.sv
// Self-checking bench: two conditioners (plain and key-inverted) against a tick-counting reference model.
module tb_de2i150_input_conditioner;

    localparam int          D      = 4;
    localparam int          ST     = 3;
    localparam int          SS     = 2;
    localparam int          MAXK   = 4096;
    localparam logic [15:0] MASK_A = 16'h0000;
    localparam logic [15:0] MASK_B = 16'h000F;
    localparam logic [15:0] RSTV   = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] raw_a, raw_b;
    logic [15:0] clean_a, rise_a, fall_a, clean_b, rise_b, fall_b;
    logic        any_a, any_b;
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
    logic [15:0] clr_a, clr_b;
    logic        irq_a, irq_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    de2i150_input_conditioner #(
        .WIDTH(16), .SYNC_STAGES(SS), .TICK_DIV(D), .STABLE_TICKS(ST),
        .INVERT_MASK(MASK_A), .RESET_VALUE(RSTV)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_a),
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        .capture_clr(clr_a), .irq(irq_a),
`endif
        .clean_out(clean_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
    );

    de2i150_input_conditioner #(
        .WIDTH(16), .SYNC_STAGES(SS), .TICK_DIV(D), .STABLE_TICKS(ST),
        .INVERT_MASK(MASK_B), .RESET_VALUE(RSTV)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_b),
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        .capture_clr(clr_b), .irq(irq_b),
`endif
        .clean_out(clean_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
    );

    // Reference model: a level is accepted once it has differed from the clean value
    // across ST prescaler ticks with no interruption. Edge k = k-th clock edge after reset release.
    logic [15:0] hist [2][MAXK];
    logic [15:0] m_clean [2];
    logic [15:0] m_rise  [2];
    logic [15:0] m_fall  [2];
    int          since   [2][16];
    logic [15:0] m_cap;
    logic        m_irq;
    int          k;

    function automatic logic [15:0] mask_of(input int n);
        return (n == 0) ? MASK_A : MASK_B;
    endfunction

    function automatic bit is_tick(input int j);
        return ((j - 1) % D) == (D - 1);
    endfunction

    function automatic int ticks_in(input int a, input int b);
        int c = 0;
        for (int j = a; j <= b; j++) if (is_tick(j)) c++;
        return c;
    endfunction

    task automatic model_reset();
        k = 0;
        m_cap = '0;
        m_irq = 1'b0;
        for (int n = 0; n < 2; n++) begin
            m_clean[n] = RSTV;
            m_rise[n]  = '0;
            m_fall[n]  = '0;
            for (int b = 0; b < 16; b++) since[n][b] = -1;
        end
    endtask

    task automatic model_edge();
        logic [15:0] s_word;
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        m_cap = (m_cap & ~clr_a) | m_rise[0] | m_fall[0];
        m_irq = |m_cap;
`endif
        k++;
        if (k >= MAXK) begin
            $display("FAIL model_history observed=%0d expected<%0d", k, MAXK);
            $fatal(1, "model history exhausted");
        end
        hist[0][k] = raw_a;
        hist[1][k] = raw_b;
        for (int n = 0; n < 2; n++) begin
            m_rise[n] = '0;
            m_fall[n] = '0;
            s_word = (k - SS >= 1) ? (hist[n][k-SS] ^ mask_of(n)) : RSTV;
            for (int b = 0; b < 16; b++) begin
                if (s_word[b] == m_clean[n][b]) begin
                    since[n][b] = -1;
                end else begin
                    if (since[n][b] < 0) since[n][b] = k;
                    if (is_tick(k) && ticks_in(since[n][b], k) == ST) begin
                        m_clean[n][b] = s_word[b];
                        m_rise[n][b]  = s_word[b];
                        m_fall[n][b]  = ~s_word[b];
                        since[n][b]   = -1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("clean_a", clean_a, m_clean[0]);
        check("rise_a",  rise_a,  m_rise[0]);
        check("fall_a",  fall_a,  m_fall[0]);
        check("any_a",   16'(any_a), 16'(|(m_rise[0] | m_fall[0])));
        check("clean_b", clean_b, m_clean[1]);
        check("rise_b",  rise_b,  m_rise[1]);
        check("fall_b",  fall_b,  m_fall[1]);
        check("any_b",   16'(any_b), 16'(|(m_rise[1] | m_fall[1])));
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        check("irq_a",   16'(irq_a), 16'(m_irq));
`endif
    endtask

    // One clock: model steps on the edge, outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        if (reset_n) check_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rises, anys, cnt;
        logic [15:0] first_rise;
        bit found;

        reset_n = 1'b0;
        raw_a   = 16'h0000;
        raw_b   = 16'h000F;
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        clr_a = '0;
        clr_b = '0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_clean_a", clean_a, RSTV);
        check("reset_pulse_a", rise_a | fall_a, 16'h0000);
        check("reset_clean_b", clean_b, RSTV);
        check("reset_any",     16'({any_a, any_b}), 16'h0000);
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        check("reset_irq",     16'(irq_a), 16'h0000);
`endif
        reset_n = 1'b1;

        // Quiet after release: no pulses for 100 cycles.
        cnt = 0;
        repeat (100) begin
            cyc();
            if (any_a || any_b) cnt++;
        end
        check("quiet_pulses", 16'(cnt), 16'h0000);

        // Clean step on bit 0.
        raw_a[0] = 1'b1;
        lat = -1; rises = 0; anys = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (lat < 0 && clean_a[0]) lat = c;
            if (rise_a[0]) rises++;
            if (any_a) anys++;
        end
        check("step_latency_ok", 16'(lat >= 11 && lat <= 14), 16'h0001);
        check("step_rise_count", 16'(rises), 16'h0001);
        check("step_any_count",  16'(anys),  16'h0001);
        check("step_clean",      clean_a, 16'h0001);

        // Bit 3 bounces every 5 cycles, then holds high.
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (c % 5 == 0) raw_a[3] = ~raw_a[3];
            cyc();
            if (rise_a[3] || fall_a[3] || clean_a[3]) cnt++;
        end
        check("bounce_no_change", 16'(cnt), 16'h0000);
        raw_a[3] = 1'b1;
        rises = 0;
        repeat (20) begin
            cyc();
            if (rise_a[3]) rises++;
        end
        check("bounce_rise_count", 16'(rises), 16'h0001);
        check("bounce_clean",      clean_a, 16'h0009);

        // Active-low key on the inverted instance.
        raw_b[1] = 1'b0;
        rises = 0;
        repeat (20) begin
            cyc();
            if (rise_b[1]) rises++;
        end
        check("invert_rise_count", 16'(rises), 16'h0001);
        check("invert_clean",      clean_b, 16'h0002);

        // All bits rise together.
        raw_a = 16'h0000;
        repeat (20) cyc();
        check("all_pre_clean", clean_a, 16'h0000);
        raw_a = 16'hFFFF;
        first_rise = '0; cnt = 0;
        repeat (20) begin
            cyc();
            if (rise_a != 16'h0000) begin
                cnt++;
                if (first_rise == 16'h0000) first_rise = rise_a;
            end
        end
        check("all_rise_word",   first_rise, 16'hFFFF);
        check("all_rise_cycles", 16'(cnt), 16'h0001);
        check("all_clean",       clean_a, 16'hFFFF);

        // Random stimulus against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 15) == 0) raw_a = 16'($urandom);
            if ($urandom_range(0, 15) == 0) raw_b = 16'($urandom);
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
            clr_a = 16'($urandom) & 16'($urandom) & 16'($urandom);
`endif
            cyc();
        end

        // Settle to a known idle state.
        raw_a = 16'h0000;
        raw_b = 16'h000F;
`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        clr_a = 16'hFFFF;
`endif
        repeat (20) cyc();
        check("idle_clean_a", clean_a, 16'h0000);
        check("idle_clean_b", clean_b, 16'h0000);

`ifdef DE2I150_INPUT_CONDITIONER_EDGE_CAPTURE_EN
        clr_a = 16'h0000;
        cyc();
        check("cap_idle_irq", 16'(irq_a), 16'h0000);
        raw_a[5] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (rise_a[5]) begin
                found = 1'b1;
                break;
            end
        end
        check("cap_rise_seen", 16'(found), 16'h0001);
        cyc();
        check("cap_irq_set", 16'(irq_a), 16'h0001);
        clr_a[5] = 1'b1;
        cyc();
        clr_a = 16'h0000;
        check("cap_irq_cleared", 16'(irq_a), 16'h0000);
        raw_a[5] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (fall_a[5]) begin
                found = 1'b1;
                break;
            end
        end
        check("cap_fall_seen", 16'(found), 16'h0001);
        clr_a[5] = 1'b1;
        cyc();
        clr_a = 16'h0000;
        check("cap_set_wins", 16'(irq_a), 16'h0001);
        repeat (5) cyc();
`endif

        // Reset mid-qualification: partial count is discarded, full latency after release.
        raw_a = 16'hFFFF;
        repeat (6) cyc();
        check("midq_no_change", clean_a, 16'h0000);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midq_reset_clean", clean_a, RSTV);
        check("midq_reset_pulse", rise_a | fall_a, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("midq_hold_pulse", 16'({any_a, any_b}), 16'h0000);
        reset_n = 1'b1;
        lat = -1; rises = 0;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (lat < 0 && clean_a == 16'hFFFF) lat = c;
            if (rise_a != 16'h0000) rises++;
        end
        check("midq_latency_ok", 16'(lat >= 11 && lat <= 14), 16'h0001);
        check("midq_rise_cycles", 16'(rises), 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
